pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
//  Owns the fetch PC register and consumes the branch predictor's outputs.
//  Each cycle it selects the next halfword PC from correction, jump, ISR, prediction or sequential sources.
//  It drives the IF/ID and ID/EXE flushes and holds redirects that arrive during a stall.
//  Sits between the BHT and the IF stage; all PCs are 11-bit halfword addresses.
// PARAMETERS
//  RESET_PC   11'h000  PC loaded on reset
//  CNT_W      16       width of perf counters (only with BP_PERF_CNT_EN)
// PORTS
//  CLK            in   1   clock, all state on posedge
//  rst            in   1   asynchronous, active-high reset
//  stall          in   1   pipeline stall; PC and flushes held while high
//  if_is_compressed in 1   fetched instr is 16-bit (seq step 1) else 32-bit (step 2)
//  if_prediction  in   1   BHT taken prediction for current if_PC
//  if_PBT         in   11  BHT predicted target for current if_PC
//  id_branchtarget in  11  decoded jump target in ID
//  jump_flush     in   1   ID jump missing from BHT (already stall-gated)
//  exe_correction in   2   00 none, 10 take exe_CNI, 11 take exe_PBT
//  exe_CNI        in   11  correct next instr after not-taken branch
//  exe_PBT        in   11  correct taken target
//  isr_req        in   1   interrupt entry request; level, held until isr_ack
//  isr_target     in   11  ISR vector (halfword), stable while isr_req high
//  isr_ack        out  1   one-cycle pulse when ISR redirect is applied
//  if_PC          out  11  current fetch PC (registered)
//  if_flush       out  1   kill instr entering IF/ID this edge
//  id_flush       out  1   kill instr entering ID/EXE this edge
//  pend_valid     out  1   a redirect is latched awaiting stall release
// BEHAVIOUR
//  Reset: if_PC=RESET_PC, state=RUN, pend_valid=0, isr_ack=0; flushes 0 while rst.
//  Next-PC priority (highest first), evaluated combinationally:
//   1 exe_correction[1]: 10->exe_CNI, 11->exe_PBT; asserts if_flush and id_flush
//   2 isr_req: isr_target; if_flush and id_flush; isr_ack=1
//   3 jump_flush: id_branchtarget; if_flush only
//   4 if_prediction: if_PBT; no flush
//   5 sequential: if_PC + (if_is_compressed ? 1 : 2), mod 2^11 (11'h7FF+1 -> 11'h000)
//  Flushes and isr_ack are combinational, registered effect at the same edge as if_PC update.
//  FSM RUN: stall=0 -> if_PC<=next. stall=1 with exe_correction!=0 -> latch target
//   into pend_pc, pend_valid<=1, go PEND; stall=1 otherwise -> hold if_PC.
//  FSM PEND: while stall=1 hold; later correction during PEND overwrites pend_pc.
//   First stall=0 cycle: if_PC<=pend_pc, if_flush=id_flush=1, pend_valid<=0, -> RUN.
//   Live exe_correction in that release cycle wins over pend_pc.
//  isr_req during stall or PEND is not acked; retried once back in RUN with stall=0.
//  Simultaneous correction + isr_req: correction taken, isr_ack=0, ISR next cycle.
//  rst mid-PEND drops pend_pc; no flush emitted after reset release.
//  Flushes never asserted while stall=1.
// CONFIGURATION
//  BP_PERF_CNT_EN defined: adds out ports mispred_cnt[CNT_W-1:0], jflush_cnt[CNT_W-1:0].
//   mispred_cnt +1 per applied exe correction (live or pending release); jflush_cnt +1 per
//   applied jump_flush. Both saturate at all-ones, clear on rst.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  rst release, stall=0, if_is_compressed=0, no preds -> if_PC 000,002,004,006.
//  if_PC=7FF, compressed=1 -> next if_PC=000 (wrap), no flush.
//  if_prediction=1, if_PBT=120 -> next if_PC=120, if_flush=0, id_flush=0.
//  stall=1, exe_correction=11, exe_PBT=050 -> pend_valid=1, if_PC held;
//   stall=0 -> if_PC=050, if_flush=id_flush=1 one cycle, pend_valid=0.
//  exe_correction=10 (CNI=044) same cycle as isr_req (target=300), jump_flush=1 ->
//   if_PC=044, isr_ack=0; next cycle if_PC=300, isr_ack=1.
//  BP_PERF_CNT_EN: 3 mispredicts + 2 jump flushes -> mispred_cnt=3, jflush_cnt=2; rst -> 0.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: picks the next halfword PC from correction, ISR, jump, prediction
// or sequential sources and parks redirects during stalls. Optional BP_PERF_CNT_EN adds perf counters.
module pc_redirect_ctrl #(
  parameter logic [10:0] RESET_PC = 11'h000
`ifdef BP_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        stall,
  input  logic        if_is_compressed,
  input  logic        if_prediction,
  input  logic [10:0] if_PBT,
  input  logic [10:0] id_branchtarget,
  input  logic        jump_flush,
  input  logic [1:0]  exe_correction,
  input  logic [10:0] exe_CNI,
  input  logic [10:0] exe_PBT,
  input  logic        isr_req,
  input  logic [10:0] isr_target,
  output logic        isr_ack,
  output logic [10:0] if_PC,
  output logic        if_flush,
  output logic        id_flush,
  output logic        pend_valid
`ifdef BP_PERF_CNT_EN
  , output logic [CNT_W-1:0] mispred_cnt
  , output logic [CNT_W-1:0] jflush_cnt
`endif
);

  typedef enum logic {RUN, PEND} state_t;

  state_t      state_q, state_d;
  logic [10:0] pc_q, pc_d;
  logic [10:0] pend_pc_q, pend_pc_d;
  logic        corr;
  logic [10:0] corr_pc;
  logic [10:0] seq_pc;
  logic        if_flush_c, id_flush_c, isr_ack_c;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      pend_pc_q <= 11'h000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_comb begin
    corr       = exe_correction[1];
    corr_pc    = exe_correction[0] ? exe_PBT : exe_CNI;
    seq_pc     = pc_q + (if_is_compressed ? 11'd1 : 11'd2);
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    if_flush_c = 1'b0;
    id_flush_c = 1'b0;
    isr_ack_c  = 1'b0;
    case (state_q)
      RUN: begin
        if (stall) begin
          if (corr) begin
            pend_pc_d = corr_pc;
            state_d   = PEND;
          end
        end else if (corr) begin
          pc_d       = corr_pc;
          if_flush_c = 1'b1;
          id_flush_c = 1'b1;
        end else if (isr_req) begin
          pc_d       = isr_target;
          if_flush_c = 1'b1;
          id_flush_c = 1'b1;
          isr_ack_c  = 1'b1;
        end else if (jump_flush) begin
          pc_d       = id_branchtarget;
          if_flush_c = 1'b1;
        end else if (if_prediction) begin
          pc_d = if_PBT;
        end else begin
          pc_d = seq_pc;
        end
      end
      PEND: begin
        if (stall) begin
          if (corr) pend_pc_d = corr_pc;
        end else begin
          // A correction arriving in the release cycle is younger than the parked one
          pc_d       = corr ? corr_pc : pend_pc_q;
          if_flush_c = 1'b1;
          id_flush_c = 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign if_PC      = pc_q;
  assign pend_valid = (state_q == PEND);
  assign if_flush   = if_flush_c & ~rst;
  assign id_flush   = id_flush_c & ~rst;
  assign isr_ack    = isr_ack_c & ~rst;

`ifdef BP_PERF_CNT_EN
  logic [CNT_W-1:0] mispred_q, mispred_d;
  logic [CNT_W-1:0] jflush_q, jflush_d;
  logic             corr_apply, jf_apply;

  always_comb begin
    corr_apply = ~stall & ((state_q == PEND) | ((state_q == RUN) & corr));
    jf_apply   = ~stall & (state_q == RUN) & ~corr & ~isr_req & jump_flush;
    mispred_d  = mispred_q;
    jflush_d   = jflush_q;
    if (corr_apply && (mispred_q != '1)) mispred_d = mispred_q + CNT_W'(1);
    if (jf_apply && (jflush_q != '1))    jflush_d  = jflush_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      mispred_q <= '0;
      jflush_q  <= '0;
    end else begin
      mispred_q <= mispred_d;
      jflush_q  <= jflush_d;
    end
  end

  assign mispred_cnt = mispred_q;
  assign jflush_cnt  = jflush_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: rule-level reference model checked every negedge
// plus literal expectations from the hand-worked scenarios.
module tb_pc_redirect_ctrl;

  logic        CLK = 1'b0;
  logic        rst;
  logic        stall, if_is_compressed, if_prediction, jump_flush, isr_req;
  logic [10:0] if_PBT, id_branchtarget, exe_CNI, exe_PBT, isr_target;
  logic [1:0]  exe_correction;
  logic        isr_ack, if_flush, id_flush, pend_valid;
  logic [10:0] if_PC;
`ifdef BP_PERF_CNT_EN
  logic [15:0] mispred_cnt, jflush_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  pc_redirect_ctrl dut (
    .CLK(CLK), .rst(rst), .stall(stall), .if_is_compressed(if_is_compressed),
    .if_prediction(if_prediction), .if_PBT(if_PBT), .id_branchtarget(id_branchtarget),
    .jump_flush(jump_flush), .exe_correction(exe_correction), .exe_CNI(exe_CNI),
    .exe_PBT(exe_PBT), .isr_req(isr_req), .isr_target(isr_target), .isr_ack(isr_ack),
    .if_PC(if_PC), .if_flush(if_flush), .id_flush(id_flush), .pend_valid(pend_valid)
`ifdef BP_PERF_CNT_EN
    , .mispred_cnt(mispred_cnt), .jflush_cnt(jflush_cnt)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: architectural PC, parked redirect, and counters.
  logic [10:0] m_pc = 11'h000;
  bit          m_parked = 0;
  logic [10:0] m_park_pc = 11'h000;
  int          m_mis = 0, m_jf = 0;

  always @(negedge CLK) begin
    bit          e_iff, e_idf, e_ack;
    logic [10:0] want;
    bit          have_corr;
    logic [10:0] corr_tgt;
    have_corr = (exe_correction == 2'b10) || (exe_correction == 2'b11);
    corr_tgt  = (exe_correction == 2'b11) ? exe_PBT : exe_CNI;
    e_iff = 0; e_idf = 0; e_ack = 0;
    if (rst) begin
      m_pc = 11'h000; m_parked = 0; m_mis = 0; m_jf = 0;
      chk("rst_pc", if_PC, 0);
      chk("rst_flags", {if_flush, id_flush, isr_ack, pend_valid}, 0);
    end else begin
      chk("m_pc", if_PC, m_pc);
      chk("m_pend", pend_valid, m_parked);
`ifdef BP_PERF_CNT_EN
      chk("m_mis", mispred_cnt, m_mis);
      chk("m_jf", jflush_cnt, m_jf);
`endif
      want = m_pc;
      if (stall) begin
        if (have_corr) begin m_parked = 1; m_park_pc = corr_tgt; end
      end else if (m_parked || have_corr) begin
        want = have_corr ? corr_tgt : m_park_pc;
        e_iff = 1; e_idf = 1; m_parked = 0;
        if (m_mis < 65535) m_mis++;
      end else if (isr_req) begin
        want = isr_target; e_iff = 1; e_idf = 1; e_ack = 1;
      end else if (jump_flush) begin
        want = id_branchtarget; e_iff = 1;
        if (m_jf < 65535) m_jf++;
      end else if (if_prediction) begin
        want = if_PBT;
      end else begin
        want = 11'((int'(m_pc) + (if_is_compressed ? 1 : 2)) % 2048);
      end
      chk("m_if_flush", if_flush, e_iff);
      chk("m_id_flush", id_flush, e_idf);
      chk("m_isr_ack", isr_ack, e_ack);
      m_pc = want;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    stall = 0; if_is_compressed = 0; if_prediction = 0; jump_flush = 0; isr_req = 0;
    if_PBT = 0; id_branchtarget = 0; exe_CNI = 0; exe_PBT = 0; isr_target = 0;
    exe_correction = 2'b00;
  endtask

  initial begin
    rst = 1; idle();
    tick(); tick();
    rst = 0;
    #1 chk("lit_pc0", if_PC, 11'h000);
    tick(); chk("lit_pc2", if_PC, 11'h002);
    tick(); chk("lit_pc4", if_PC, 11'h004);
    tick(); chk("lit_pc6", if_PC, 11'h006);

    if_prediction = 1; if_PBT = 11'h7FF;
    tick(); chk("lit_pc7ff", if_PC, 11'h7FF);
    if_prediction = 0; if_is_compressed = 1;
    #1 chk("lit_wrap_noflush", if_flush, 0);
    tick(); chk("lit_wrap", if_PC, 11'h000);

    if_prediction = 1; if_PBT = 11'h120;
    #1 chk("lit_pred_flush", {if_flush, id_flush}, 0);
    tick(); chk("lit_pred_pc", if_PC, 11'h120);
    if_prediction = 0;

    stall = 1; exe_correction = 2'b11; exe_PBT = 11'h050;
    #1 chk("lit_stall_noflush", {if_flush, id_flush}, 0);
    tick(); chk("lit_pend_v", pend_valid, 1); chk("lit_pend_hold", if_PC, 11'h120);
    exe_correction = 2'b00;
    tick(); chk("lit_pend_hold2", if_PC, 11'h120);
    stall = 0;
    #1 chk("lit_rel_flush", {if_flush, id_flush}, 2'b11);
    tick(); chk("lit_rel_pc", if_PC, 11'h050); chk("lit_rel_pv", pend_valid, 0);
    chk("lit_rel_oneshot", if_flush, 0);

    exe_correction = 2'b10; exe_CNI = 11'h044; isr_req = 1; isr_target = 11'h300; jump_flush = 1;
    #1 chk("lit_corr_isr_ack", isr_ack, 0);
    tick(); chk("lit_corr_pc", if_PC, 11'h044);
    exe_correction = 2'b00; jump_flush = 0;
    #1 chk("lit_isr_ack", isr_ack, 1);
    tick(); chk("lit_isr_pc", if_PC, 11'h300);
    isr_req = 0;

    stall = 1; exe_correction = 2'b11; exe_PBT = 11'h0AA;
    tick(); exe_correction = 2'b10; exe_CNI = 11'h0BB;
    tick(); stall = 0; exe_correction = 2'b11; exe_PBT = 11'h0CC;
    tick(); chk("lit_live_wins", if_PC, 11'h0CC);
    exe_correction = 2'b00;

    jump_flush = 1; id_branchtarget = 11'h200;
    #1 chk("lit_jf_flush", {if_flush, id_flush}, 2'b10);
    tick(); chk("lit_jf_pc", if_PC, 11'h200);
    jump_flush = 0;

    stall = 1; isr_req = 1; isr_target = 11'h3A0;
    #1 chk("lit_isr_stall", isr_ack, 0);
    tick(); stall = 0;
    #1 chk("lit_isr_retry", isr_ack, 1);
    tick(); chk("lit_isr_retry_pc", if_PC, 11'h3A0);
    isr_req = 0;

    stall = 1; exe_correction = 2'b11; exe_PBT = 11'h055;
    tick(); chk("lit_pend_before_rst", pend_valid, 1);
    rst = 1; exe_correction = 2'b00;
    #1 chk("lit_rst_pend", pend_valid, 0); chk("lit_rst_pc", if_PC, 11'h000);
    tick(); rst = 0; stall = 0; if_is_compressed = 0;
    #1 chk("lit_rst_noflush", {if_flush, id_flush}, 0);
    tick(); chk("lit_rst_seq", if_PC, 11'h002);

    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 2);
      exe_correction   = (r == 0) ? 2'b00 : ((r == 1) ? 2'b10 : 2'b11);
      if ($urandom_range(0, 2) != 0) exe_correction = 2'b00;
      stall            = ($urandom_range(0, 3) == 0);
      isr_req          = ($urandom_range(0, 5) == 0);
      jump_flush       = ($urandom_range(0, 4) == 0);
      if_prediction    = ($urandom_range(0, 2) == 0);
      if_is_compressed = 1'($urandom_range(0, 1));
      if_PBT = 11'($urandom); id_branchtarget = 11'($urandom);
      exe_CNI = 11'($urandom); exe_PBT = 11'($urandom); isr_target = 11'($urandom);
      tick();
    end
    idle();
    tick();

`ifdef BP_PERF_CNT_EN
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin exe_correction = 2'b10; exe_CNI = 11'(i * 16); tick(); end
    exe_correction = 2'b00;
    for (int i = 0; i < 2; i++) begin jump_flush = 1; id_branchtarget = 11'h100; tick(); end
    jump_flush = 0;
    #1 chk("lit_mis3", mispred_cnt, 3); chk("lit_jf2", jflush_cnt, 2);
    rst = 1;
    #1 chk("lit_cnt_clr", {mispred_cnt, jflush_cnt}, 0);
    tick(); rst = 0; tick();
`endif

    @(negedge CLK); #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
